// File: rtl/hk628_audio_pkg.sv
// Shared audio types, frame geometry and the slot bit-selection rule for the I2S transmitter.
// HK628_LEFT_JUSTIFIED_EN selects left-justified slot formatting instead of standard I2S.
package hk628_audio_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned SLOT_W     = 32;
    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int unsigned SLOT_IDX_W = $clog2(SLOT_W);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    // Serial bit for frame position bc; upper bit of bc selects the channel.
    function automatic logic slot_bit(input stereo_t f, input logic [BIT_CNT_W-1:0] bc);
        logic [SLOT_IDX_W-1:0] b;
        sample_t               s;
        logic                  bit_v;
        b     = bc[SLOT_IDX_W-1:0];
        s     = bc[BIT_CNT_W-1] ? f.r : f.l;
        bit_v = 1'b0;
`ifdef HK628_LEFT_JUSTIFIED_EN
        if (b <= 5'd15) begin
            bit_v = s[4'(5'd15 - b)];
        end
`else
        if ((b >= 5'd1) && (b <= 5'd16)) begin
            bit_v = s[4'(5'd16 - b)];
        end
`endif
        return bit_v;
    endfunction

endpackage

// File: rtl/hk628_i2s_tx_if.sv
// Stereo sample handshake between the PCM core and the I2S transmitter.
interface hk628_i2s_tx_if;
    import hk628_audio_pkg::*;

    sample_t in_l;
    sample_t in_r;
    logic    in_valid;
    logic    in_ready;

    modport master (output in_l, output in_r, output in_valid, input in_ready);
    modport slave  (input in_l, input in_r, input in_valid, output in_ready);

endinterface

// File: rtl/hk628_sync_fifo.sv
// Single-clock FIFO of stereo frames; simultaneous push and pop are both honoured.
module hk628_sync_fifo
    import hk628_audio_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  stereo_t                wr_data,
    output stereo_t                rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    stereo_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/hk628_i2s_tx.sv
// I2S transmitter: buffers stereo samples and serialises them as SCLK/LRCLK/SDATA.
// Define HK628_LEFT_JUSTIFIED_EN for left-justified slot formatting.
module hk628_i2s_tx
    import hk628_audio_pkg::*;
#(
    parameter int unsigned SCLK_HALF_DIV = 8,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    hk628_i2s_tx_if.slave in_if,
    input  logic          clr_underrun,
    output logic          underrun,
    output logic          frame_strobe,
    output logic          i2s_sclk,
    output logic          i2s_lrclk,
    output logic          i2s_sdata
);
    localparam int unsigned DIV_W = $clog2(SCLK_HALF_DIV);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_next;
    stereo_t              frame_q;
    stereo_t              frame_next;
    stereo_t              fifo_head;
    stereo_t              fifo_wdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 push;
    logic                 pop;
    logic                 div_tc;
    logic                 sclk_fall;
    logic                 load;

    assign in_if.in_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push           = in_if.in_valid && !fifo_full;

    always_comb begin
        fifo_wdata   = '0;
        fifo_wdata.l = in_if.in_l;
        fifo_wdata.r = in_if.in_r;
    end

    hk628_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (fifo_wdata),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Frame boundary is the SCLK fall that wraps the bit counter 63 -> 0.
    always_comb begin
        div_tc     = (div_cnt == DIV_W'(SCLK_HALF_DIV - 1));
        sclk_fall  = div_tc && i2s_sclk;
        bit_next   = bit_cnt + BIT_CNT_W'(1);
        load       = sclk_fall && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
        pop        = load && !fifo_empty;
        frame_next = pop ? fifo_head : frame_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            i2s_sclk     <= 1'b0;
            bit_cnt      <= BIT_CNT_W'(FRAME_BITS - 1);
            i2s_lrclk    <= 1'b0;
            i2s_sdata    <= 1'b0;
            frame_q      <= '0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (div_tc) begin
                div_cnt  <= '0;
                i2s_sclk <= ~i2s_sclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (sclk_fall) begin
                bit_cnt   <= bit_next;
                i2s_lrclk <= bit_next[BIT_CNT_W-1];
                i2s_sdata <= slot_bit(frame_next, bit_next);
                if (load) begin
                    frame_q      <= frame_next;
                    frame_strobe <= 1'b1;
                end
            end
            // An empty load repeats the held frame; setting beats clearing.
            if (load && fifo_empty) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hk628_i2s_tx.sv
// Randomised scoreboard bench for hk628_i2s_tx against a frame-level timing and data model.
module tb_hk628_i2s_tx;
    import hk628_audio_pkg::*;

    localparam int unsigned HALF       = 8;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned BITCLKS    = 2 * HALF;
    localparam int unsigned FRAME_CLKS = 64 * BITCLKS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clr_underrun = 1'b0;
    logic underrun, frame_strobe, i2s_sclk, i2s_lrclk, i2s_sdata;

    hk628_i2s_tx_if sif();

    hk628_i2s_tx #(
        .SCLK_HALF_DIV (HALF),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_if        (sif),
        .clr_underrun (clr_underrun),
        .underrun     (underrun),
        .frame_strobe (frame_strobe),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata)
    );

    always #10 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          armed = 1'b0;
    logic [31:0] exp_q[$];
    int          m_count = 0;
    bit          m_load = 1'b0;
    bit          m_pop_ok = 1'b0;
    bit          m_under = 1'b0;
    logic [31:0] held = '0;

    function automatic bit is_load(input int k);
        return (k >= int'(BITCLKS)) && (((k - int'(BITCLKS)) % int'(FRAME_CLKS)) == 0);
    endfunction

    // Whole frame as transmitted, MSB first on the wire.
    function automatic logic [63:0] frame_vec(input logic [31:0] f);
`ifdef HK628_LEFT_JUSTIFIED_EN
        return {f[31:16], 16'b0, f[15:0], 16'b0};
`else
        return {1'b0, f[31:16], 15'b0, 1'b0, f[15:0], 15'b0};
`endif
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    // Model: FIFO occupancy, acceptance and underrun rule, evaluated per clock.
    always @(posedge clk) begin
        int sz;
        if (reset) begin
            armed    = 1'b1;
            cyc      = 0;
            exp_q.delete();
            m_count  = 0;
            m_load   = 1'b0;
            m_pop_ok = 1'b0;
            m_under  = 1'b0;
        end else if (armed) begin
            cyc++;
            sz       = m_count;
            m_load   = is_load(cyc);
            m_pop_ok = m_load && (sz > 0);
            if (m_load && (sz == 0)) m_under = 1'b1;
            else if (clr_underrun)   m_under = 1'b0;
            if (m_pop_ok) m_count--;
            if (sif.in_valid && (sz < int'(DEPTH))) begin
                exp_q.push_back({sif.in_l, sif.in_r});
                m_count++;
            end
        end
    end

    // Monitor: pops the scoreboard on each frame load and checks every pin.
    always @(negedge clk) begin
        int          pos;
        logic [63:0] v;
        logic        exp_lr, exp_sd;
        if (armed) begin
            if (cyc == 0) held = '0;
            chk("frame_strobe", frame_strobe, m_load);
            if (m_load && m_pop_ok) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty cyc=%0d actual=pop required=entry", cyc);
                end else begin
                    held = exp_q.pop_front();
                end
            end
            if (cyc >= int'(BITCLKS)) begin
                pos    = ((cyc - int'(BITCLKS)) / int'(BITCLKS)) % 64;
                v      = frame_vec(held);
                exp_lr = (pos >= 32);
                exp_sd = v[63-pos];
            end else begin
                exp_lr = 1'b0;
                exp_sd = 1'b0;
            end
            chk("sclk", i2s_sclk, 1'(((cyc / int'(HALF)) % 2)));
            chk("lrclk", i2s_lrclk, exp_lr);
            chk("sdata", i2s_sdata, exp_sd);
            chk("underrun", underrun, m_under);
            chk("in_ready", sif.in_ready, (m_count < int'(DEPTH)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] l, input logic [15:0] r);
        sif.in_valid = 1'b1;
        sif.in_l     = l;
        sif.in_r     = r;
        tick();
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_pre_load();
        bit found = 1'b0;
        for (int i = 0; i < int'(FRAME_CLKS) + 4; i++) begin
            if (is_load(cyc + 1)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_load_timeout cyc=%0d actual=none required=load", cyc);
        end
    endtask

    task automatic wait_bit20();
        bit found = 1'b0;
        for (int i = 0; i < int'(FRAME_CLKS) + 4; i++) begin
            if ((cyc >= int'(BITCLKS)) && ((((cyc - int'(BITCLKS)) / int'(BITCLKS)) % 64) == 20)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_bit20_timeout cyc=%0d actual=none required=bit20", cyc);
        end
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_l     = '0;
        sif.in_r     = '0;
        reset        = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Idle start: empty loads, silent output, underrun.
        repeat (FRAME_CLKS + 100) tick();
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;

        // Directed patterns, then repeat of the last one.
        push_one(16'hA5C3, 16'h8001);
        push_one(16'h8000, 16'h7FFF);
        repeat (3 * FRAME_CLKS) tick();

        // Continuous valid with fresh random data every clock.
        sif.in_valid = 1'b1;
        for (int i = 0; i < int'(5 * FRAME_CLKS); i++) begin
            sif.in_l = 16'($urandom_range(0, 65535));
            sif.in_r = 16'($urandom_range(0, 65535));
            tick();
        end
        sif.in_valid = 1'b0;

        // Drain, then clear coincident with an empty load.
        repeat (5 * FRAME_CLKS) tick();
        wait_pre_load();
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        repeat (40) tick();
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;

        // Mid-frame reset with three frames queued.
        wait_pre_load();
        tick();
        for (int i = 0; i < 3; i++) begin
            push_one(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end
        wait_bit20();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (FRAME_CLKS + 200) tick();

        // Random bursts of valid and clear.
        for (int i = 0; i < int'(3 * FRAME_CLKS); i++) begin
            sif.in_valid = 1'($urandom_range(0, 1));
            sif.in_l     = 16'($urandom_range(0, 65535));
            sif.in_r     = 16'($urandom_range(0, 65535));
            clr_underrun = ($urandom_range(0, 63) == 0);
            tick();
        end
        sif.in_valid = 1'b0;
        clr_underrun = 1'b0;
        repeat (2 * FRAME_CLKS) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
